// File: rtl/gray_frame_ctrl.sv
// Frame-scan sequencer: reads each pixel, passes it through the external grayscale
// filter (or bypasses it) and writes it back in place. Optional macro GRAY_CTRL_FRAMECNT_EN adds frame_cnt.
module gray_frame_ctrl #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [23:0]       mem_rd_data,
   output logic              mem_wr_en,
   output logic [23:0]       mem_wr_data,
   input  logic [23:0]       filt_out,
`ifdef GRAY_CTRL_FRAMECNT_EN
   output logic [23:0]       filt_in,
   output logic [7:0]        frame_cnt
`else
   output logic [23:0]       filt_in
`endif
);

   localparam int N = H_RES * V_RES;
   localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
   localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'(RD_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] cnt_reg, cnt_next;
   logic [WC_W-1:0]   wait_reg, wait_next;
   logic              mode_reg, mode_next;
   logic [23:0]       pix_reg, pix_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         wait_reg  <= '0;
         mode_reg  <= 1'b0;
         pix_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         wait_reg  <= wait_next;
         mode_reg  <= mode_next;
         pix_reg   <= pix_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      wait_next  = wait_reg;
      mode_next  = mode_reg;
      pix_next   = pix_reg;
      busy       = 1'b0;
      done       = 1'b0;
      mem_rd_en  = 1'b0;
      mem_wr_en  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            cnt_next = '0;
            // abort has priority over a coincident start
            if (!abort && start) begin
               mode_next  = mode;
               state_next = S_READ;
            end
         end
         S_READ: begin
            busy       = 1'b1;
            mem_rd_en  = 1'b1;
            wait_next  = WAIT_LOAD;
            state_next = abort ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (abort) begin
               state_next = S_IDLE;
            end else if (wait_reg == '0) begin
               pix_next   = mem_rd_data;
               state_next = S_WRITE;
            end else begin
               wait_next = wait_reg - WC_W'(1);
            end
         end
         S_WRITE: begin
            busy      = 1'b1;
            mem_wr_en = !abort;
            if (abort) begin
               state_next = S_IDLE;
            end else if (cnt_reg == LAST_ADDR) begin
               state_next = S_DONE;
            end else begin
               cnt_next   = cnt_reg + ADDR_W'(1);
               state_next = S_READ;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign mem_addr    = cnt_reg;
   assign filt_in     = pix_reg;
   assign mem_wr_data = mode_reg ? filt_out : pix_reg;

`ifdef GRAY_CTRL_FRAMECNT_EN
   logic [7:0] frame_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         frame_cnt_reg <= '0;
      else if (state_reg == S_DONE)
         frame_cnt_reg <= frame_cnt_reg + 8'd1;
   end

   assign frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Bench for gray_frame_ctrl: two instances (RD_LAT=2 and RD_LAT=1) on a 4x2 frame,
// each with its own BRAM model and an averaging grayscale filter.
module tb_gray_frame_ctrl;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int N  = H * V;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst;
   logic start [2];
   logic abort [2];
   logic mode  [2];
   logic busy  [2];
   logic done  [2];
   logic rd_en [2];
   logic wr_en [2];
   logic [AW-1:0] addr [2];
   logic [23:0] rd_data  [2];
   logic [23:0] wr_data  [2];
   logic [23:0] filt_in  [2];
   logic [23:0] filt_out [2];
`ifdef GRAY_CTRL_FRAMECNT_EN
   logic [7:0] frame_cnt [2];
`endif

   always #5 clk = ~clk;

   function automatic logic [23:0] gray(input logic [23:0] p);
      int s;
      s = (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) / 3;
      return {3{8'(s)}};
   endfunction

   function automatic int lat(input int i);
      return 2 - i;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         assign filt_out[gi] = gray(filt_in[gi]);
         gray_frame_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .RD_LAT(2 - gi)) dut (
            .clk(clk), .rst(rst), .start(start[gi]), .abort(abort[gi]), .mode(mode[gi]),
            .busy(busy[gi]), .done(done[gi]), .mem_addr(addr[gi]), .mem_rd_en(rd_en[gi]),
            .mem_rd_data(rd_data[gi]), .mem_wr_en(wr_en[gi]), .mem_wr_data(wr_data[gi]),
            .filt_out(filt_out[gi]),
`ifdef GRAY_CTRL_FRAMECNT_EN
            .frame_cnt(frame_cnt[gi]),
`endif
            .filt_in(filt_in[gi])
         );
      end
   endgenerate

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int t0 = 0;
   logic [23:0] mem  [2][N];
   logic [23:0] orig [2][N];
   logic        pv   [2][2];
   logic [AW-1:0] pa [2][2];
   logic mode_ref  [2];
   logic prev_busy [2];
   int   wr_cnt [2];
   int   done_cnt [2];
   int   done_rel [2];
   int   last_wr [2];
   int   frames [2];

   typedef struct {
      logic [23:0] pix;
      logic        m;
      logic [23:0] exp;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [23:0] ref_pix(input int i, input int a);
      return mode_ref[i] ? gray(orig[i][a]) : orig[i][a];
   endfunction

   // One clock: sample at negedge, update BRAM model at posedge, present read data #1 later.
   task automatic step();
      logic          cw [2];
      logic          cr [2];
      logic [AW-1:0] ca [2];
      logic [23:0]   cd [2];
      int            rel;
      @(negedge clk);
      rel = cyc - t0;
      for (int i = 0; i < 2; i++) begin
         cw[i] = wr_en[i];
         cr[i] = rd_en[i];
         ca[i] = addr[i];
         cd[i] = wr_data[i];
         if (wr_en[i]) begin
            if (wr_cnt[i] > 0)
               chk($sformatf("wr_gap[%0d]", i), rel - last_wr[i], 2 + lat(i));
            chk($sformatf("wr_addr[%0d]", i), longint'(addr[i]), wr_cnt[i]);
            chk($sformatf("wr_data[%0d]", i), wr_data[i], ref_pix(i, int'(addr[i])));
            wr_cnt[i]++;
            last_wr[i] = rel;
         end
         if (done[i]) begin
            done_cnt[i]++;
            done_rel[i] = rel;
            chk($sformatf("busy_fall_at_done[%0d]", i), {prev_busy[i], busy[i]}, 2'b10);
         end
         prev_busy[i] = busy[i];
      end
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (cw[i]) mem[i][ca[i]] = cd[i];
         pv[i][1] = pv[i][0];
         pa[i][1] = pa[i][0];
         pv[i][0] = cr[i];
         pa[i][0] = ca[i];
      end
      #1;
      for (int i = 0; i < 2; i++)
         rd_data[i] = pv[i][lat(i)-1] ? mem[i][pa[i][lat(i)-1]] : 24'hA5A5A5;
   endtask

   task automatic arm(input logic m);
      for (int i = 0; i < 2; i++) begin
         for (int a = 0; a < N; a++) orig[i][a] = mem[i][a];
         mode_ref[i] = m;
         wr_cnt[i]   = 0;
         done_cnt[i] = 0;
         done_rel[i] = -1;
         last_wr[i]  = 0;
      end
   endtask

   task automatic preload(input logic rnd, input logic [23:0] val);
      for (int i = 0; i < 2; i++)
         for (int a = 0; a < N; a++)
            mem[i][a] = rnd ? 24'($urandom) : val;
   endtask

   task automatic run_pass(input logic [1:0] mask, input logic m, input int extra_rel,
                           input logic do_abort, input logic rnd_start, input int tail);
      int ab [2];
      int len;
      arm(m);
      for (int i = 0; i < 2; i++) begin
         ab[i] = 4 * (2 + lat(i));  // WRITE cycle of pixel 3
         start[i] = mask[i];
         mode[i]  = m;
      end
      t0  = cyc;
      len = N * 4 + 1 + tail;
      for (int k = 1; k <= len; k++) begin
         step();
         for (int i = 0; i < 2; i++) begin
            start[i] = mask[i] && (k == extra_rel ||
                       (rnd_start && k < 20 && $urandom_range(0, 1) == 1));
            abort[i] = mask[i] && do_abort && k == ab[i];
            mode[i]  = 1'($urandom_range(0, 1));
            if (mask[i] && do_abort && k == ab[i] + 1)
               chk($sformatf("busy_after_abort[%0d]", i), busy[i], 1'b0);
         end
      end
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0;
         abort[i] = 1'b0;
         if (!mask[i]) begin
            chk($sformatf("idle_writes[%0d]", i), wr_cnt[i], 0);
         end else if (do_abort) begin
            chk($sformatf("abort_writes[%0d]", i), wr_cnt[i], 3);
            chk($sformatf("abort_done[%0d]", i), done_cnt[i], 0);
            for (int a = 0; a < N; a++)
               chk($sformatf("abort_mem[%0d][%0d]", i, a), mem[i][a],
                   (a < 3) ? ref_pix(i, a) : orig[i][a]);
         end else begin
            chk($sformatf("writes[%0d]", i), wr_cnt[i], N);
            chk($sformatf("done_cnt[%0d]", i), done_cnt[i], 1);
            chk($sformatf("done_time[%0d]", i), done_rel[i], N * (2 + lat(i)) + 1);
            frames[i]++;
            for (int a = 0; a < N; a++)
               chk($sformatf("mem[%0d][%0d]", i, a), mem[i][a], ref_pix(i, a));
         end
`ifdef GRAY_CTRL_FRAMECNT_EN
         chk($sformatf("frame_cnt[%0d]", i), frame_cnt[i], frames[i] % 256);
`endif
      end
   endtask

   initial begin
      tbl[0] = '{24'h102030, 1'b1, 24'h202020};
      tbl[1] = '{24'h00FF00, 1'b0, 24'h00FF00};
      tbl[2] = '{24'hFFFFFF, 1'b1, 24'hFFFFFF};
      tbl[3] = '{24'h030609, 1'b1, 24'h060606};
      tbl[4] = '{24'h010000, 1'b1, 24'h000000};
      tbl[5] = '{24'h123456, 1'b0, 24'h123456};

      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0; abort[i] = 1'b0; mode[i] = 1'b0; rd_data[i] = '0;
         pv[i][0] = 1'b0; pv[i][1] = 1'b0; pa[i][0] = '0; pa[i][1] = '0;
         prev_busy[i] = 1'b0; frames[i] = 0;
      end
      preload(1'b0, 24'h0);
      arm(1'b0);

      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++)
         chk($sformatf("reset_outputs[%0d]", i),
             {busy[i], done[i], rd_en[i], wr_en[i], addr[i], wr_data[i], filt_in[i]}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      step();

      for (int v = 0; v < 6; v++) begin
         preload(1'b0, tbl[v].pix);
         run_pass(2'b11, tbl[v].m, -1, 1'b0, 1'b0, 4);
         for (int i = 0; i < 2; i++)
            for (int a = 0; a < N; a++)
               chk($sformatf("vec%0d_mem[%0d][%0d]", v, i, a), mem[i][a], tbl[v].exp);
      end

      for (int r = 0; r < 4; r++) begin
         preload(1'b1, 24'h0);
         run_pass(2'b11, 1'($urandom_range(0, 1)), -1, 1'b0, 1'b1, 4);
      end

      preload(1'b1, 24'h0);
      run_pass(2'b11, 1'b1, 10, 1'b0, 1'b0, 40);   // start again while busy
      run_pass(2'b01, 1'b1, 33, 1'b0, 1'b0, 40);   // start during the DONE cycle
      preload(1'b1, 24'h0);
      run_pass(2'b11, 1'b1, -1, 1'b1, 1'b0, 4);    // abort in WRITE of pixel 3

      arm(1'b0);
      t0 = cyc;
      for (int i = 0; i < 2; i++) begin start[i] = 1'b1; abort[i] = 1'b1; end
      step();
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0; abort[i] = 1'b0;
         chk($sformatf("start_abort_busy[%0d]", i), {busy[i], rd_en[i]}, 2'b00);
      end
      for (int k = 0; k < 8; k++) step();
      for (int i = 0; i < 2; i++)
         chk($sformatf("start_abort_writes[%0d]", i), wr_cnt[i], 0);

      preload(1'b1, 24'h0);
      arm(1'b1);
      t0 = cyc;
      for (int i = 0; i < 2; i++) begin start[i] = 1'b1; mode[i] = 1'b1; end
      step();
      for (int i = 0; i < 2; i++) start[i] = 1'b0;
      for (int k = 0; k < 9; k++) step();
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("midpass_reset[%0d]", i),
             {busy[i], done[i], rd_en[i], wr_en[i], addr[i], wr_data[i], filt_in[i]}, 0);
         frames[i] = 0;
`ifdef GRAY_CTRL_FRAMECNT_EN
         chk($sformatf("reset_frame_cnt[%0d]", i), frame_cnt[i], 0);
`endif
      end
      begin
         int wc [2];
         for (int i = 0; i < 2; i++) wc[i] = wr_cnt[i];
         for (int k = 0; k < 5; k++) step();
         for (int i = 0; i < 2; i++)
            chk($sformatf("writes_in_reset[%0d]", i), wr_cnt[i], wc[i]);
      end
      rst = 1'b0;
      step();
      run_pass(2'b11, 1'b0, -1, 1'b0, 1'b0, 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
